sum_seq_ctrl: RTL and testbench
===============================

# sum_seq_ctrl

- Parametrised sequencer for the memory-accumulator adder datapath.
- On a start handshake it:
  - optionally clears the accumulator;
  - streams reads over a programmable, wrapping address window, issuing one read per cycle with a configurable memory read latency;
  - transfers the sum and writes it to a programmable destination address.
- Sits between the host/testbench and the RAM + accumulator.
- Drives the same strobe set as the existing controller (address, rden, wren, load, transf, clear, ready), adding done/err/abort.

## Interface
Parameters:
- ADDR_W, 5: address width.
- DEPTH, 32: memory words; 2 ≤ DEPTH ≤ 2^ADDR_W.
- RD_LAT, 1: memory read latency in cycles, 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start request; sampled only while ready=1.
- base_addr  in  ADDR_W  first read address; latched at start.
- count  in  ADDR_W+1  number of words to sum, 0..DEPTH; latched at start.
- dst_addr  in  ADDR_W  write-back address; latched at start.
- acc_keep  in  1  0: clear accumulator before summing; 1: continue from the held sum.
- abort  in  1  synchronous abort while busy.
- address  out  ADDR_W  memory address.
- rden  out  1  memory read strobe.
- wren  out  1  memory write strobe.
- load  out  1  accumulator adds memory read data this cycle.
- clear  out  1  accumulator clear.
- transf  out  1  copy accumulator into the write-data register.
- ready  out  1  idle and able to accept start.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on a rejected start.

## Operation
- **States:** IDLE, CLEAR, RUN, DRAIN, TRANSF, WRITE.
- **Reset values:**
  - ready=1.
  - address, rden, wren, load, clear, transf, done, err all 0.
  - Load pipe empty; state IDLE.
- **IDLE:**
  - ready=1, address=0.
  - start=1 with count ≤ DEPTH and base_addr < DEPTH:
    - latch base_addr, count, dst_addr, acc_keep;
    - go to CLEAR if acc_keep=0, else to RUN (or TRANSF if count=0).
  - Otherwise, a start with invalid count or base_addr: err=1 for one cycle, state stays IDLE.
- **CLEAR:** clear=1 for one cycle, then RUN (or TRANSF if count=0).
- **RUN:**
  - One cycle per word: rden=1, address=ptr.
  - ptr starts at base and increments modulo DEPTH: DEPTH-1 → 0.
  - After count reads, go to DRAIN.
- **Load pipe:** each rden pushes a token; load=1 exactly RD_LAT cycles after each rden.
- **DRAIN:** wait until the pipe is empty; last load is RD_LAT cycles after the last rden.
- **TRANSF:** transf=1 for one cycle.
- **WRITE:** wren=1 for one cycle, then IDLE.
- **address outside RUN and IDLE:** dst_q.
- **Completion:** on the return to IDLE after WRITE, done=1 and ready=1 in the same cycle.
- **abort:**
  - Sampled in any non-IDLE state.
  - Next cycle: IDLE, all strobes 0, pipe flushed, done=0, no write.
  - Ignored in IDLE.
- **Mutual exclusion:** strobes are never simultaneous except rden with load in RUN.

## Timing
- start is sampled at edge 0; C = 1 if acc_keep=0, else 0.
- N > 0:
  - rden in cycles C+1..C+N.
  - load in cycles C+1+RD_LAT..C+N+RD_LAT.
  - transf at C+N+RD_LAT+1.
  - wren at C+N+RD_LAT+2.
  - done and ready at C+N+RD_LAT+3.
- N = 0:
  - transf at C+1, wren at C+2, done at C+3.
  - Writes the cleared (0) or held sum.
- Throughput: one word per cycle, no bubbles.
- Back-to-back: start may be asserted in the done cycle and is accepted.
- Reset mid-operation forces the reset values immediately, with no write completed.

## Structure
- Shared header sum_seq_defs.vh:
  - state encodings;
  - RD_LAT_MAX=4;
  - the DEPTH/ADDR_W legality check constant.
- Sub-module load_pipe:
  - RD_LAT-deep valid shift register;
  - input push, synchronous flush; outputs load and empty.
- Top module holds the FSM, the pointer/counter and the latched parameters.

## Test plan
- **Basic sum:** ADDR_W=5, DEPTH=32, RD_LAT=1; start with base=0, count=4, dst=31, acc_keep=0.
  - clear at cycle 1; rden at cycles 2-5 with addresses 0,1,2,3; load at cycles 3-6.
  - transf at 7, wren at 8 with address 31, done at 9.
- **Wrap:** DEPTH=20, base=18, count=4.
  - Read addresses 18,19,0,1; never 20.
- **Latency:** RD_LAT=3, count=2, acc_keep=1.
  - No clear; rden at 1-2; load at 4-5; transf at 6; done at 8.
- **Zero count / reject:**
  - count=0, acc_keep=0: clear at 1, transf at 2, wren at 3, done at 4, no rden.
  - count=33: err pulse, ready stays 1.
- **Abort / reset:**
  - abort at the second rden cycle: idle next cycle, no wren, no done.
  - reset low mid-RUN: all outputs return to reset values immediately.
- **Back-to-back:** second start in the done cycle is accepted; start while busy is ignored.

Source files
------------

// File: rtl/sum_seq_ctrl_pkg.sv
// Shared definitions for the memory-accumulator sequencer: state codes, latency
// ceiling and the DEPTH/ADDR_W legality check.
package sum_seq_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StClear  = 3'd1;
    localparam state_t StRun    = 3'd2;
    localparam state_t StDrain  = 3'd3;
    localparam state_t StTransf = 3'd4;
    localparam state_t StWrite  = 3'd5;

    localparam int unsigned RD_LAT_MAX = 4;

    function automatic bit depth_legal(int unsigned depth, int unsigned addr_w);
        return (depth >= 2) && (depth <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/sum_seq_ctrl_load_pipe.sv
// Read-latency tracker: one valid bit per outstanding read, load fires when a
// token reaches the last stage.
module sum_seq_ctrl_load_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic flush,
    output logic load,
    output logic empty
);

    logic [RD_LAT-1:0] valid_q, valid_d, behind;

    always_comb begin
        valid_d = (valid_q << 1) | RD_LAT'(push);
        if (flush) begin
            valid_d = '0;
        end
        // empty means nothing queued behind the token loading this cycle
        behind             = valid_q;
        behind[RD_LAT-1]   = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign load  = valid_q[RD_LAT-1];
    assign empty = (behind == '0);

endmodule

// File: rtl/sum_seq_ctrl.sv
// Sequencer for the RAM + accumulator datapath: optional clear, wrapping read
// burst with a fixed read latency, then transfer and write-back of the sum.
module sum_seq_ctrl
    import sum_seq_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              acc_keep,
    input  logic              abort,
    output logic [ADDR_W-1:0] address,
    output logic              rden,
    output logic              wren,
    output logic              load,
    output logic              clear,
    output logic              transf,
    output logic              ready,
    output logic              done,
    output logic              err
);

    if (!depth_legal(DEPTH, ADDR_W) || (RD_LAT < 1) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_param
        $error("sum_seq_ctrl: illegal DEPTH/ADDR_W/RD_LAT combination");
    end

    localparam logic [ADDR_W:0]   DepthW   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              start_ok, kill, pipe_empty;

    assign start_ok = ({1'b0, base_addr} < DepthW) && (count <= DepthW);
    assign kill     = abort && (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (kill) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (start_ok) begin
                            ptr_d = base_addr;
                            cnt_d = count;
                            dst_d = dst_addr;
                            if (!acc_keep) begin
                                state_d = StClear;
                            end else if (count == '0) begin
                                state_d = StTransf;
                            end else begin
                                state_d = StRun;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StClear:  state_d = (cnt_q == '0) ? StTransf : StRun;
                StRun: begin
                    ptr_d = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == (ADDR_W+1)'(1)) begin
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    if (pipe_empty) begin
                        state_d = StTransf;
                    end
                end
                StTransf: state_d = StWrite;
                StWrite: begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dst_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    sum_seq_ctrl_load_pipe #(
        .RD_LAT(RD_LAT)
    ) u_load_pipe (
        .clk  (clk),
        .reset(reset),
        .push (rden),
        .flush(kill),
        .load (load),
        .empty(pipe_empty)
    );

    always_comb begin
        address = dst_q;
        if (state_q == StIdle) begin
            address = '0;
        end else if (state_q == StRun) begin
            address = ptr_q;
        end
    end

    assign rden   = (state_q == StRun);
    assign clear  = (state_q == StClear);
    assign transf = (state_q == StTransf);
    assign wren   = (state_q == StWrite);
    assign ready  = (state_q == StIdle);
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Self-checking bench: three parameterisations driven by shared stimulus, checked
// against a timing-formula model, a directed vector table and hand sequences.
module tb_sum_seq_ctrl;

    localparam int NDUT = 3;
    localparam logic [7:0] R   = 8'h80;
    localparam logic [7:0] W   = 8'h40;
    localparam logic [7:0] L   = 8'h20;
    localparam logic [7:0] CL  = 8'h10;
    localparam logic [7:0] T   = 8'h08;
    localparam logic [7:0] RDY = 8'h04;
    localparam logic [7:0] DN  = 8'h02;
    localparam logic [7:0] ER  = 8'h01;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] base_addr;
    logic [5:0] count;
    logic [4:0] dst_addr;
    logic       acc_keep;
    logic       abort;

    logic [4:0]  addr_o [NDUT];
    logic [7:0]  strb   [NDUT];
    logic [12:0] obs    [NDUT];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // model state per DUT
    bit m_busy [NDUT];
    bit m_done [NDUT];
    bit m_err  [NDUT];
    int m_t    [NDUT];
    int m_c    [NDUT];
    int m_n    [NDUT];
    int m_base [NDUT];
    int m_dst  [NDUT];

    sum_seq_ctrl #(.ADDR_W(5), .DEPTH(32), .RD_LAT(1)) u_a (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .dst_addr(dst_addr), .acc_keep(acc_keep), .abort(abort), .address(addr_o[0]),
        .rden(strb[0][7]), .wren(strb[0][6]), .load(strb[0][5]), .clear(strb[0][4]),
        .transf(strb[0][3]), .ready(strb[0][2]), .done(strb[0][1]), .err(strb[0][0])
    );

    sum_seq_ctrl #(.ADDR_W(5), .DEPTH(20), .RD_LAT(1)) u_b (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .dst_addr(dst_addr), .acc_keep(acc_keep), .abort(abort), .address(addr_o[1]),
        .rden(strb[1][7]), .wren(strb[1][6]), .load(strb[1][5]), .clear(strb[1][4]),
        .transf(strb[1][3]), .ready(strb[1][2]), .done(strb[1][1]), .err(strb[1][0])
    );

    sum_seq_ctrl #(.ADDR_W(5), .DEPTH(32), .RD_LAT(3)) u_c (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .dst_addr(dst_addr), .acc_keep(acc_keep), .abort(abort), .address(addr_o[2]),
        .rden(strb[2][7]), .wren(strb[2][6]), .load(strb[2][5]), .clear(strb[2][4]),
        .transf(strb[2][3]), .ready(strb[2][2]), .done(strb[2][1]), .err(strb[2][0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep_of(int d);
        return (d == 1) ? 20 : 32;
    endfunction

    function automatic int lat_of(int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic int tr_of(int d);
        return (m_n[d] > 0) ? m_c[d] + m_n[d] + lat_of(d) + 1 : m_c[d] + 1;
    endfunction

    // Expected {address, strobes} for the current cycle, from the timing rules.
    function automatic logic [12:0] model_out(int d);
        logic [7:0] s;
        logic [4:0] a;
        int t, c, n, l, tr;
        s = 8'h00;
        a = 5'd0;
        if (!m_busy[d]) begin
            s[2] = 1'b1;
            s[1] = m_done[d];
            s[0] = m_err[d];
        end else begin
            t  = m_t[d];
            c  = m_c[d];
            n  = m_n[d];
            l  = lat_of(d);
            tr = tr_of(d);
            a  = 5'(m_dst[d]);
            if (c == 1 && t == 1) s[4] = 1'b1;
            if (n > 0 && t >= c + 1 && t <= c + n) begin
                s[7] = 1'b1;
                a    = 5'((m_base[d] + t - c - 1) % dep_of(d));
            end
            if (n > 0 && t >= c + 1 + l && t <= c + n + l) s[5] = 1'b1;
            if (t == tr) s[3] = 1'b1;
            if (t == tr + 1) s[6] = 1'b1;
        end
        return {a, s};
    endfunction

    task automatic model_edge(int d);
        if (!m_busy[d]) begin
            m_done[d] = 1'b0;
            m_err[d]  = 1'b0;
            if (start) begin
                if (int'(count) <= dep_of(d) && int'(base_addr) < dep_of(d)) begin
                    m_busy[d] = 1'b1;
                    m_t[d]    = 1;
                    m_c[d]    = acc_keep ? 0 : 1;
                    m_n[d]    = int'(count);
                    m_base[d] = int'(base_addr);
                    m_dst[d]  = int'(dst_addr);
                end else begin
                    m_err[d] = 1'b1;
                end
            end
        end else if (abort) begin
            m_busy[d] = 1'b0;
            m_done[d] = 1'b0;
            m_err[d]  = 1'b0;
        end else begin
            m_t[d] = m_t[d] + 1;
            if (m_t[d] == tr_of(d) + 2) begin
                m_busy[d] = 1'b0;
                m_done[d] = 1'b1;
                m_err[d]  = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_busy[d] = 1'b0;
            m_done[d] = 1'b0;
            m_err[d]  = 1'b0;
            m_t[d]    = 0;
        end
    endtask

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got addr=%0d strobes=%b, want addr=%0d strobes=%b",
                     name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
        end
    endtask

    // Compare mid-cycle, then advance the model on the edge that samples the inputs.
    task automatic step(input bit use_vec, input logic [12:0] vexp);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            obs[d] = {addr_o[d], strb[d]};
            chk($sformatf("model dut%0d cyc%0d", d, cyc), obs[d], model_out(d));
        end
        if (use_vec) chk($sformatf("vec cyc%0d", cyc), obs[0], vexp);
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) model_edge(d);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic s, input logic [4:0] b, input logic [5:0] n,
                         input logic [4:0] dd, input logic k, input logic ab);
        start     = s;
        base_addr = b;
        count     = n;
        dst_addr  = dd;
        acc_keep  = k;
        abort     = ab;
    endtask

    task automatic idle_steps(input int n);
        drive(1'b0, 5'd0, 6'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) step(1'b0, 13'd0);
    endtask

    typedef struct {
        logic       s;
        logic [4:0] b;
        logic [5:0] n;
        logic [4:0] dd;
        logic       k;
        logic       ab;
        logic [7:0] es;
        logic [4:0] ea;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic [4:0] b, input logic [5:0] n,
                       input logic [4:0] dd, input logic k, input logic ab,
                       input logic [7:0] es, input logic [4:0] ea);
        vec_t v;
        v = '{s, b, n, dd, k, ab, es, ea};
        tbl.push_back(v);
    endtask

    task automatic add_idle(input logic [7:0] es, input logic [4:0] ea);
        add(1'b0, 5'd0, 6'd0, 5'd0, 1'b0, 1'b0, es, ea);
    endtask

    logic [12:0] exp_wrap [4];
    logic [12:0] exp_lat  [8];

    initial begin
        // basic sum
        add(1'b1, 5'd0, 6'd4, 5'd31, 1'b0, 1'b0, RDY, 5'd0);
        add_idle(CL, 5'd31);
        add_idle(R, 5'd0);
        add_idle(R | L, 5'd1);
        add_idle(R | L, 5'd2);
        add_idle(R | L, 5'd3);
        add_idle(L, 5'd31);
        add_idle(T, 5'd31);
        add_idle(W, 5'd31);
        add_idle(RDY | DN, 5'd0);
        // rejected count
        add(1'b1, 5'd0, 6'd33, 5'd0, 1'b0, 1'b0, RDY, 5'd0);
        add_idle(RDY | ER, 5'd0);
        add_idle(RDY, 5'd0);
        // zero count with clear, then back-to-back start in the done cycle
        add(1'b1, 5'd0, 6'd0, 5'd5, 1'b0, 1'b0, RDY, 5'd0);
        add_idle(CL, 5'd5);
        add_idle(T, 5'd5);
        add_idle(W, 5'd5);
        add(1'b1, 5'd30, 6'd3, 5'd7, 1'b1, 1'b0, RDY | DN, 5'd0);
        add_idle(R, 5'd30);
        add_idle(R | L, 5'd31);
        add_idle(R | L, 5'd0);
        add_idle(L, 5'd7);
        add_idle(T, 5'd7);
        add_idle(W, 5'd7);
        add_idle(RDY | DN, 5'd0);
        // abort on the second read
        add(1'b1, 5'd0, 6'd5, 5'd2, 1'b1, 1'b0, RDY, 5'd0);
        add_idle(R, 5'd0);
        add(1'b0, 5'd0, 6'd0, 5'd0, 1'b0, 1'b1, R | L, 5'd1);
        add_idle(RDY, 5'd0);
        add_idle(RDY, 5'd0);
        // start while busy is ignored
        add(1'b1, 5'd4, 6'd2, 5'd9, 1'b1, 1'b0, RDY, 5'd0);
        add(1'b1, 5'd10, 6'd10, 5'd1, 1'b0, 1'b0, R, 5'd4);
        add(1'b1, 5'd10, 6'd10, 5'd1, 1'b0, 1'b0, R | L, 5'd5);
        add_idle(L, 5'd9);
        add_idle(T, 5'd9);
        add_idle(W, 5'd9);
        add_idle(RDY | DN, 5'd0);
        add_idle(RDY, 5'd0);

        exp_wrap = '{{5'd18, R}, {5'd19, R | L}, {5'd0, R | L}, {5'd1, R | L}};
        exp_lat  = '{{5'd3, R}, {5'd4, R}, {5'd6, 8'h00}, {5'd6, L}, {5'd6, L},
                     {5'd6, T}, {5'd6, W}, {5'd0, RDY | DN}};

        reset = 1'b0;
        drive(1'b0, 5'd0, 6'd0, 5'd0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) chk($sformatf("reset dut%0d", d), {addr_o[d], strb[d]},
                                             {5'd0, RDY});
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].s, tbl[i].b, tbl[i].n, tbl[i].dd, tbl[i].k, tbl[i].ab);
            step(1'b1, {tbl[i].ea, tbl[i].es});
        end
        idle_steps(6);

        // wrap on the DEPTH=20 instance
        drive(1'b1, 5'd18, 6'd4, 5'd0, 1'b1, 1'b0);
        step(1'b0, 13'd0);
        drive(1'b0, 5'd0, 6'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 13'd0);
            chk($sformatf("wrap read %0d", i), obs[1], exp_wrap[i]);
        end
        idle_steps(8);

        // read latency 3 on the third instance
        drive(1'b1, 5'd3, 6'd2, 5'd6, 1'b1, 1'b0);
        step(1'b0, 13'd0);
        drive(1'b0, 5'd0, 6'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 13'd0);
            chk($sformatf("latency cyc%0d", i + 1), obs[2], exp_lat[i]);
        end
        idle_steps(3);

        // asynchronous reset in the middle of a read burst
        drive(1'b1, 5'd0, 6'd8, 5'd3, 1'b0, 1'b0);
        step(1'b0, 13'd0);
        drive(1'b0, 5'd0, 6'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 13'd0);
        #2;
        reset = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) chk($sformatf("mid reset dut%0d", d),
                                             {addr_o[d], strb[d]}, {5'd0, RDY});
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_steps(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                  6'($urandom_range(0, 36)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
            step(1'b0, 13'd0);
        end
        idle_steps(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
